// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg: two-entry MEM/WB pipeline register with a skid slot,
// writeback mux and register-write qualification.
module mem_wb_skid_reg #(
  parameter int DATA_W           = 64,
  parameter int RD_W             = 5,
  parameter bit ZERO_RD_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic              in_regWrite,
  input  logic              in_MemtoReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_mem_data,
  output logic              out_MemtoReg,
  output logic              out_regWrite,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] mem_data;
    logic              regWrite;
    logic              MemtoReg;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_ent;
  logic   push, pop;
  logic   load_main_in, load_main_skid, load_skid;
  logic   rd_ok;

  assign in_ent = '{rd:       in_rd,
                    result:   in_result,
                    mem_data: in_mem_data,
                    regWrite: in_regWrite,
                    MemtoReg: in_MemtoReg};

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          push & pop: load_main_in = 1'b1;
          push & ~pop: begin
            load_skid = 1'b1;
            state_d   = FULL;
          end
          pop & ~push: state_d = EMPTY;
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        if (pop) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // push/pop are already gated by flush, so no loads happen here
    if (flush) state_d = EMPTY;
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_ent;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_ent;
      end
    end
  end

  assign out_rd         = main_q.rd;
  assign out_alu_result = main_q.result;
  assign out_mem_data   = main_q.mem_data;
  assign out_MemtoReg   = main_q.MemtoReg;
  assign out_wb_data    = main_q.MemtoReg ? main_q.mem_data
                                          : main_q.result;

  assign rd_ok = ZERO_RD_SUPPRESS ? (main_q.rd != '0) : 1'b1;
  assign out_regWrite = out_valid & main_q.regWrite & rd_ok;

endmodule
